// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin front end for a single shared 8-bit rotate stage.
// Two clients request rotates through valid/ready. One winner is latched into
// the sh_* registers and held there for a DRIVE cycle. The stage result is then
// captured and returned to that client, and the block returns to IDLE.
module shift_arbiter #(
  parameter int DW        = 8,
  parameter int AW        = 3,
  parameter bit PRIO_INIT = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    req_valid,
  output logic [1:0]    req_ready,
  input  logic [DW-1:0] req_data0,
  input  logic [DW-1:0] req_data1,
  input  logic [AW-1:0] req_amt0,
  input  logic [AW-1:0] req_amt1,
  input  logic          req_dir0,
  input  logic          req_dir1,
  output logic [1:0]    rsp_valid,
  input  logic [1:0]    rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic [DW-1:0] sh_a,
  output logic [AW-1:0] sh_amt,
  output logic          sh_dir,
  input  logic [DW-1:0] sh_y,
  output logic          busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  state_e        state_q;
  logic          rr_q;        // last granted requester
  logic          owner_q;     // requester owning the in-flight operation
  logic          busy_q;
  logic [1:0]    rsp_valid_q;
  logic [DW-1:0] rsp_data_q;
  logic [DW-1:0] sh_a_q;
  logic [AW-1:0] sh_amt_q;
  logic          sh_dir_q;

  logic          gnt_d;
  logic [1:0]    rdy_d;
  logic          hs_d;
  logic [DW-1:0] sh_a_d;
  logic [AW-1:0] sh_amt_d;
  logic          sh_dir_d;

  // Arbitration: only offered in IDLE; a lone request wins outright, a
  // contended one goes to the requester not granted last time. Ready is
  // withheld during reset so no client believes it was accepted while the
  // block is being cleared.
  always_comb begin
    gnt_d = 1'b0;
    rdy_d = 2'b00;
    if ((state_q == ST_IDLE) && !reset) begin
      unique case (req_valid)
        2'b01: begin
          gnt_d = 1'b0;
          rdy_d = 2'b01;
        end
        2'b10: begin
          gnt_d = 1'b1;
          rdy_d = 2'b10;
        end
        2'b11: begin
          gnt_d = ~rr_q;
          rdy_d = rr_q ? 2'b01 : 2'b10;
        end
        default: begin
          gnt_d = 1'b0;
          rdy_d = 2'b00;
        end
      endcase
    end
  end

  // Operand select for the granted requester and handshake detection.
  always_comb begin
    hs_d     = |(req_valid & rdy_d);
    sh_a_d   = gnt_d ? req_data1 : req_data0;
    sh_amt_d = gnt_d ? req_amt1  : req_amt0;
    sh_dir_d = gnt_d ? req_dir1  : req_dir0;
  end

  // Sequencer: latch operands, let the shared stage settle for one cycle,
  // capture its result, then hold the response until the owner takes it.
  // The sh_* registers only change on an accept, so the shared stage sees
  // steady inputs at all other times.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rr_q        <= ~PRIO_INIT;
      owner_q     <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= '0;
      sh_a_q      <= '0;
      sh_amt_q    <= '0;
      sh_dir_q    <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (hs_d) begin
            sh_a_q   <= sh_a_d;
            sh_amt_q <= sh_amt_d;
            sh_dir_q <= sh_dir_d;
            owner_q  <= gnt_d;
            rr_q     <= gnt_d;
            busy_q   <= 1'b1;
            state_q  <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          rsp_data_q  <= sh_y;
          rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready[owner_q]) begin
            rsp_valid_q <= 2'b00;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 2'b00;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready = rdy_d;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign sh_a      = sh_a_q;
  assign sh_amt    = sh_amt_q;
  assign sh_dir    = sh_dir_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level reference model. A rotate-stage model drives sh_y.
module tb_shift_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [7:0] req_data0, req_data1, rsp_data, sh_a, sh_y;
  logic [2:0] req_amt0, req_amt1, sh_amt;
  logic       req_dir0, req_dir1, sh_dir, busy;

  int checks = 0;
  int failures = 0;

  // Reference state kept by the bench
  logic       m_rr;
  logic [7:0] last_a;
  logic [2:0] last_amt;
  logic       last_dir;

  always #5 clk = ~clk;

  function automatic logic [7:0] rot(input logic [7:0] a, input logic [2:0] n, input logic d);
    logic [15:0] t;
    t = {a, a};
    if (!d) begin
      t = t << n;
      return t[15:8];
    end
    t = t >> n;
    return t[7:0];
  endfunction

  function automatic logic pick(input logic [1:0] v, input logic rr);
    if (v == 2'b01) return 1'b0;
    if (v == 2'b10) return 1'b1;
    return ~rr;
  endfunction

  assign sh_y = rot(sh_a, sh_amt, sh_dir);

  shift_arbiter #(.DW(8), .AW(3), .PRIO_INIT(1'b0)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data0(req_data0), .req_data1(req_data1),
    .req_amt0(req_amt0), .req_amt1(req_amt1),
    .req_dir0(req_dir0), .req_dir1(req_dir1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .sh_a(sh_a), .sh_amt(sh_amt), .sh_dir(sh_dir), .sh_y(sh_y),
    .busy(busy)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    step; step;
    reset = 1'b0;
    m_rr = 1'b1; last_a = 8'h00; last_amt = 3'd0; last_dir = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    #1;
    checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
    checks++; if (rsp_data !== 8'h00) begin failures++; $display("FAIL reset_rsp_data got=%h exp=00", rsp_data); end
    checks++; if ({sh_a, sh_amt, sh_dir} !== 12'h000) begin failures++; $display("FAIL reset_sh got=%h/%0d/%b exp=0", sh_a, sh_amt, sh_dir); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
  endtask

  task automatic test_single_op;
    req_valid = 2'b01; req_data0 = 8'h81; req_amt0 = 3'd1; req_dir0 = 1'b0; rsp_ready = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL single_ready got=%b exp=01", req_ready); end
    step;
    m_rr = 1'b0; last_a = 8'h81; last_amt = 3'd1; last_dir = 1'b0;
    req_valid = 2'b00; req_data0 = 8'h5A; req_amt0 = 3'd6; req_dir0 = 1'b1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
    checks++; if ({sh_a, sh_amt, sh_dir} !== {8'h81, 3'd1, 1'b0}) begin failures++; $display("FAIL single_sh got=%h/%0d/%b exp=81/1/0", sh_a, sh_amt, sh_dir); end
    checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL single_early_rsp got=%b exp=00", rsp_valid); end
    step;
    checks++; if (rsp_valid !== 2'b01) begin failures++; $display("FAIL single_rsp_valid got=%b exp=01", rsp_valid); end
    checks++; if (rsp_data !== 8'h03) begin failures++; $display("FAIL single_rsp_data got=%h exp=03", rsp_data); end
    step;
    checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL single_rsp_clear got=%b exp=00", rsp_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle got=%b exp=0", busy); end
  endtask

  task automatic test_right_and_zero;
    logic [2:0] amts [2];
    logic [7:0] exps [2];
    amts[0] = 3'd1; amts[1] = 3'd0;
    exps[0] = 8'hC0; exps[1] = 8'h81;
    for (int i = 0; i < 2; i++) begin
      req_valid = 2'b10; req_data1 = 8'h81; req_amt1 = amts[i]; req_dir1 = 1'b1; rsp_ready = 2'b11;
      #1;
      checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL right%0d_ready got=%b exp=10", i, req_ready); end
      step;
      m_rr = 1'b1; last_a = 8'h81; last_amt = amts[i]; last_dir = 1'b1;
      req_valid = 2'b00;
      step;
      checks++; if (rsp_valid !== 2'b10) begin failures++; $display("FAIL right%0d_rsp_valid got=%b exp=10", i, rsp_valid); end
      checks++; if (rsp_data !== exps[i]) begin failures++; $display("FAIL right%0d_rsp_data got=%h exp=%h", i, rsp_data, exps[i]); end
      step;
    end
  endtask

  task automatic test_contention;
    logic       g;
    logic [7:0] exp_d;
    do_reset;
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int op = 0; op < 4; op++) begin
      req_data0 = $urandom; req_amt0 = $urandom; req_dir0 = $urandom;
      req_data1 = $urandom; req_amt1 = $urandom; req_dir1 = $urandom;
      #1;
      g = pick(2'b11, m_rr);
      checks++; if (g !== op[0]) begin failures++; $display("FAIL contend_model op%0d got=%b exp=%b", op, g, op[0]); end
      checks++; if (req_ready !== (g ? 2'b10 : 2'b01)) begin failures++; $display("FAIL contend_ready op%0d got=%b exp_grant=%b", op, req_ready, g); end
      exp_d = g ? rot(req_data1, req_amt1, req_dir1) : rot(req_data0, req_amt0, req_dir0);
      last_a = g ? req_data1 : req_data0; last_amt = g ? req_amt1 : req_amt0; last_dir = g ? req_dir1 : req_dir0;
      step;
      m_rr = g;
      req_data0 = $urandom; req_data1 = $urandom;
      checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL contend_drive_ready op%0d got=%b exp=00", op, req_ready); end
      step;
      checks++; if (rsp_valid !== (g ? 2'b10 : 2'b01)) begin failures++; $display("FAIL contend_rsp_valid op%0d got=%b grant=%b", op, rsp_valid, g); end
      checks++; if (rsp_data !== exp_d) begin failures++; $display("FAIL contend_rsp_data op%0d got=%h exp=%h", op, rsp_data, exp_d); end
      checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL contend_resp_ready op%0d got=%b exp=00", op, req_ready); end
      step;
    end
    req_valid = 2'b00;
  endtask

  task automatic test_backpressure;
    logic [7:0] exp_d;
    req_valid = 2'b01; req_data0 = $urandom; req_amt0 = $urandom; req_dir0 = $urandom; rsp_ready = 2'b00;
    exp_d = rot(req_data0, req_amt0, req_dir0);
    last_a = req_data0; last_amt = req_amt0; last_dir = req_dir0;
    step;
    m_rr = 1'b0;
    req_valid = 2'b11;
    step;
    for (int c = 0; c < 5; c++) begin
      checks++; if (rsp_valid !== 2'b01) begin failures++; $display("FAIL bp_hold_valid c%0d got=%b exp=01", c, rsp_valid); end
      checks++; if (rsp_data !== exp_d) begin failures++; $display("FAIL bp_hold_data c%0d got=%h exp=%h", c, rsp_data, exp_d); end
      checks++; if ((req_ready !== 2'b00) || (busy !== 1'b1)) begin failures++; $display("FAIL bp_hold_ctl c%0d ready=%b busy=%b exp=00/1", c, req_ready, busy); end
      rsp_ready = (c >= 3) ? 2'b10 : 2'b00;
      step;
    end
    checks++; if (rsp_valid !== 2'b01) begin failures++; $display("FAIL bp_nonowner_ready got=%b exp=01", rsp_valid); end
    rsp_ready = 2'b01;
    step;
    checks++; if ((rsp_valid !== 2'b00) || (busy !== 1'b0)) begin failures++; $display("FAIL bp_release valid=%b busy=%b exp=00/0", rsp_valid, busy); end
    checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL bp_fair_next got=%b exp=10", req_ready); end
    last_a = req_data1; last_amt = req_amt1; last_dir = req_dir1;
    rsp_ready = 2'b11;
    step;
    m_rr = 1'b1;
    req_valid = 2'b00;
    step; step;
  endtask

  task automatic test_reset_mid_op;
    req_valid = 2'b01; req_data0 = 8'hA5; req_amt0 = 3'd3; req_dir0 = 1'b1; rsp_ready = 2'b11;
    step;
    req_valid = 2'b11; reset = 1'b1;
    step;
    checks++; if ((rsp_valid !== 2'b00) || (busy !== 1'b0)) begin failures++; $display("FAIL rst_mid_ctl valid=%b busy=%b exp=00/0", rsp_valid, busy); end
    checks++; if ({sh_a, sh_amt, sh_dir, rsp_data} !== 20'h0) begin failures++; $display("FAIL rst_mid_data sh=%h/%0d/%b rsp=%h exp=0", sh_a, sh_amt, sh_dir, rsp_data); end
    step;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_no_accept got=%b exp=0", busy); end
    reset = 1'b0;
    m_rr = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rst_prio got=%b exp=01", req_ready); end
    req_data0 = 8'h3C; req_amt0 = 3'd2; req_dir0 = 1'b0;
    last_a = 8'h3C; last_amt = 3'd2; last_dir = 1'b0;
    step;
    m_rr = 1'b0;
    req_valid = 2'b00;
    step;
    checks++; if ((rsp_valid !== 2'b01) || (rsp_data !== 8'hF0)) begin failures++; $display("FAIL rst_after_op valid=%b data=%h exp=01/f0", rsp_valid, rsp_data); end
    step;
  endtask

  task automatic test_idle_stability;
    req_valid = 2'b00;
    for (int c = 0; c < 10; c++) begin
      req_data0 = $urandom; req_data1 = $urandom; req_amt0 = $urandom; req_amt1 = $urandom;
      req_dir0 = $urandom; req_dir1 = $urandom; rsp_ready = $urandom;
      #1;
      checks++; if ((req_ready !== 2'b00) || (rsp_valid !== 2'b00) || (busy !== 1'b0)) begin failures++; $display("FAIL idle_ctl c%0d ready=%b valid=%b busy=%b", c, req_ready, rsp_valid, busy); end
      checks++; if ({sh_a, sh_amt, sh_dir} !== {last_a, last_amt, last_dir}) begin failures++; $display("FAIL idle_sh_hold c%0d got=%h/%0d/%b exp=%h/%0d/%b", c, sh_a, sh_amt, sh_dir, last_a, last_amt, last_dir); end
      step;
    end
  endtask

  task automatic test_random;
    logic       pend = 1'b0;
    int         age = 0;
    logic       owner = 1'b0;
    logic [7:0] exp_d = 8'h00;
    logic [1:0] exp_rdy, exp_vld;
    logic       g;
    for (int c = 0; c < 400; c++) begin
      exp_vld = (pend && age >= 1) ? (owner ? 2'b10 : 2'b01) : 2'b00;
      checks++; if (rsp_valid !== exp_vld) begin failures++; $display("FAIL rand_rsp_valid c%0d got=%b exp=%b", c, rsp_valid, exp_vld); end
      if (exp_vld != 2'b00) begin
        checks++; if (rsp_data !== exp_d) begin failures++; $display("FAIL rand_rsp_data c%0d got=%h exp=%h", c, rsp_data, exp_d); end
      end
      checks++; if (busy !== pend) begin failures++; $display("FAIL rand_busy c%0d got=%b exp=%b", c, busy, pend); end
      checks++; if ({sh_a, sh_amt, sh_dir} !== {last_a, last_amt, last_dir}) begin failures++; $display("FAIL rand_sh c%0d got=%h/%0d/%b exp=%h/%0d/%b", c, sh_a, sh_amt, sh_dir, last_a, last_amt, last_dir); end
      req_valid = $urandom; rsp_ready = $urandom;
      req_data0 = $urandom; req_data1 = $urandom; req_amt0 = $urandom; req_amt1 = $urandom;
      req_dir0 = $urandom; req_dir1 = $urandom;
      #1;
      g = pick(req_valid, m_rr);
      exp_rdy = (!pend && req_valid != 2'b00) ? (g ? 2'b10 : 2'b01) : 2'b00;
      checks++; if (req_ready !== exp_rdy) begin failures++; $display("FAIL rand_ready c%0d got=%b exp=%b", c, req_ready, exp_rdy); end
      if (!pend && exp_rdy != 2'b00) begin
        pend = 1'b1; age = 0; owner = g; m_rr = g;
        exp_d = g ? rot(req_data1, req_amt1, req_dir1) : rot(req_data0, req_amt0, req_dir0);
        last_a = g ? req_data1 : req_data0; last_amt = g ? req_amt1 : req_amt0; last_dir = g ? req_dir1 : req_dir0;
      end else if (pend) begin
        if (age >= 1 && rsp_ready[owner]) pend = 1'b0;
        else age++;
      end
      step;
    end
    req_valid = 2'b00; rsp_ready = 2'b11;
    step; step; step;
  endtask

  initial begin
    reset = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    req_data0 = 8'h00; req_data1 = 8'h00; req_amt0 = 3'd0; req_amt1 = 3'd0;
    req_dir0 = 1'b0; req_dir1 = 1'b0;
    m_rr = 1'b1; last_a = 8'h00; last_amt = 3'd0; last_dir = 1'b0;
    test_reset;
    test_single_op;
    test_right_and_zero;
    test_contention;
    test_backpressure;
    test_reset_mid_op;
    test_idle_stability;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
